// File: rtl/ex_stage_if.sv
// Handshake and ALU bundle for the execute stage.
// slave is the stage's view; master is the surrounding pipeline/ALU.
interface ex_stage_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_rs_val;
  logic [W-1:0] in_rt_val;
  logic [4:0]   in_rs_idx;
  logic [4:0]   in_rt_idx;
  logic [15:0]  in_imm;
  logic [4:0]   in_rd;
  logic         flush;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [4:0]   out_rd;
  logic         out_wb_en;
  logic         out_br_taken;
  logic         err_illegal;

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_rs_val,
    input  in_rt_val,
    input  in_rs_idx,
    input  in_rt_idx,
    input  in_imm,
    input  in_rd,
    input  flush,
    input  alu_out,
    input  alu_zero,
    input  out_ready,
    output in_ready,
    output alu_a,
    output alu_b,
    output alu_sel,
    output out_valid,
    output out_data,
    output out_rd,
    output out_wb_en,
    output out_br_taken,
    output err_illegal
  );

  modport master (
    output in_valid,
    output in_op,
    output in_rs_val,
    output in_rt_val,
    output in_rs_idx,
    output in_rt_idx,
    output in_imm,
    output in_rd,
    output flush,
    output alu_out,
    output alu_zero,
    output out_ready,
    input  in_ready,
    input  alu_a,
    input  alu_b,
    input  alu_sel,
    input  out_valid,
    input  out_data,
    input  out_rd,
    input  out_wb_en,
    input  out_br_taken,
    input  err_illegal
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID/EX feeds an external ALU, EX/MEM captures its result.
// Define EX_FORWARD_EN to forward EX and EX/MEM results into new operands.
module ex_stage #(
  parameter int W = 32
) (
  input logic     clk,
  input logic     rst,
  ex_stage_if.slave bus
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [4:0]   rd;
    logic         wb_en;
    logic         beq;
    logic         bne;
  } id_ex_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic [4:0]   rd;
    logic         wb_en;
    logic         br_taken;
  } ex_mem_t;

  logic         ex_valid;
  id_ex_t       ex_q;
  id_ex_t       ex_d;
  logic         out_valid;
  ex_mem_t      out_q;
  ex_mem_t      out_d;
  logic         err_q;

  logic         adv;
  logic         ready;
  logic         accept;
  logic         legal;
  logic         load_ex;
  logic         drain;
  logic [W-1:0] imm_ext;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;

  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_or;
  logic is_xor;
  logic is_addi;
  logic is_beq;
  logic is_bne;

  // flush takes priority over advancing the ID/EX entry
  assign adv = ex_valid & ~bus.flush
             & (~out_valid | bus.out_ready);
  assign ready = ~rst & ~bus.flush
               & (~ex_valid | adv);
  assign accept  = bus.in_valid & ready;
  assign legal   = ~bus.in_op[3];
  assign load_ex = accept & legal;
  assign drain   = out_valid & bus.out_ready;
  assign imm_ext = {{(W-16){bus.in_imm[15]}}, bus.in_imm};

  assign is_add  = bus.in_op == 4'd0;
  assign is_sub  = bus.in_op == 4'd1;
  assign is_and  = bus.in_op == 4'd2;
  assign is_or   = bus.in_op == 4'd3;
  assign is_xor  = bus.in_op == 4'd4;
  assign is_addi = bus.in_op == 4'd5;
  assign is_beq  = bus.in_op == 4'd6;
  assign is_bne  = bus.in_op == 4'd7;

`ifdef EX_FORWARD_EN
  always_comb begin
    rs_val = bus.in_rs_val;
    if (bus.in_rs_idx != 5'd0 && ex_valid
        && ex_q.wb_en && ex_q.rd == bus.in_rs_idx)
      rs_val = bus.alu_out;
    else if (bus.in_rs_idx != 5'd0 && out_valid
             && out_q.wb_en && out_q.rd == bus.in_rs_idx)
      rs_val = out_q.data;
  end

  always_comb begin
    rt_val = bus.in_rt_val;
    if (!is_addi && bus.in_rt_idx != 5'd0 && ex_valid
        && ex_q.wb_en && ex_q.rd == bus.in_rt_idx)
      rt_val = bus.alu_out;
    else if (!is_addi && bus.in_rt_idx != 5'd0
             && out_valid && out_q.wb_en
             && out_q.rd == bus.in_rt_idx)
      rt_val = out_q.data;
  end
`else
  logic unused_idx;
  assign unused_idx = ^{bus.in_rs_idx, bus.in_rt_idx};
  assign rs_val = bus.in_rs_val;
  assign rt_val = bus.in_rt_val;
`endif

  always_comb begin
    ex_d       = '0;
    ex_d.a     = rs_val;
    ex_d.b     = is_addi ? imm_ext : rt_val;
    ex_d.rd    = bus.in_rd;
    ex_d.beq   = is_beq;
    ex_d.bne   = is_bne;
    ex_d.wb_en = legal & ~is_beq & ~is_bne
               & (bus.in_rd != 5'd0);
    unique case (1'b1)
      is_add | is_addi:          ex_d.sel = 3'b000;
      is_sub | is_beq | is_bne:  ex_d.sel = 3'b001;
      is_and:                    ex_d.sel = 3'b010;
      is_or:                     ex_d.sel = 3'b011;
      is_xor:                    ex_d.sel = 3'b100;
      default:                   ex_d.sel = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (load_ex) begin
      ex_valid <= 1'b1;
      ex_q     <= ex_d;
    end else if (adv | bus.flush) begin
      ex_valid <= 1'b0;
    end
  end

  always_comb begin
    out_d          = '0;
    out_d.data     = bus.alu_out;
    out_d.rd       = ex_q.rd;
    out_d.wb_en    = ex_q.wb_en;
    out_d.br_taken = (ex_q.beq & bus.alu_zero)
                   | (ex_q.bne & ~bus.alu_zero);
  end

  // EX/MEM fields only change on adv, so they hold while MEM stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_q     <= out_d;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept & ~legal)
      err_q <= 1'b1;
  end

  assign bus.in_ready     = ready;
  assign bus.alu_a        = ex_q.a;
  assign bus.alu_b        = ex_q.b;
  assign bus.alu_sel      = ex_q.sel;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_q.data;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_wb_en    = out_q.wb_en;
  assign bus.out_br_taken = out_q.br_taken;
  assign bus.err_illegal  = err_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table, hand sequences,
// and a random stream checked against a queue-based op model.
module tb_ex_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if #(.W(W)) bus ();
  ex_stage #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // behavioural ALU
  always_comb begin
    case (bus.alu_sel)
      3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = '0;
    endcase
    bus.alu_zero = (bus.alu_out == '0);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
  } res_t;

  function automatic res_t model(input logic [3:0] op,
                                 input logic [31:0] rs,
                                 input logic [31:0] rt,
                                 input logic [15:0] imm,
                                 input logic [4:0] rd);
    res_t r;
    logic [31:0] se;
    se = {{16{imm[15]}}, imm};
    r.rd = rd;
    r.br = 1'b0;
    r.wb = (op <= 4'd5) && (rd != 5'd0);
    case (op)
      4'd0: r.data = rs + rt;
      4'd1: r.data = rs - rt;
      4'd2: r.data = rs & rt;
      4'd3: r.data = rs | rt;
      4'd4: r.data = rs ^ rt;
      4'd5: r.data = rs + se;
      4'd6: begin r.data = rs - rt; r.br = (rs == rt); end
      4'd7: begin r.data = rs - rt; r.br = (rs != rt); end
      default: r.data = '0;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic [31:0] e_data;
    logic        e_wb;
    logic        e_br;
  } vec_t;

  vec_t vt[10];

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs_val = '0;
    bus.in_rt_val = '0;
    bus.in_rs_idx = '0;
    bus.in_rt_idx = '0;
    bus.in_imm    = '0;
    bus.in_rd     = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic send(input logic [3:0] op,
                      input logic [31:0] rs,
                      input logic [31:0] rt,
                      input logic [15:0] imm,
                      input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_rs_val = rs;
    bus.in_rt_val = rt;
    bus.in_imm    = imm;
    bus.in_rd     = rd;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [31:0] eb;
    eb = (v.op == 4'd5) ? {{16{v.imm[15]}}, v.imm} : v.rt;
    @(negedge clk);
    send(v.op, v.rs, v.rt, v.imm, v.rd);
    bus.out_ready = 1'b1;
    #1 chk($sformatf("v%0d_in_ready", k), 32'(bus.in_ready), 1);
    @(negedge clk);
    idle();
    #1;
    chk($sformatf("v%0d_lat1", k), 32'(bus.out_valid), 0);
    chk($sformatf("v%0d_alu_a", k), bus.alu_a, v.rs);
    chk($sformatf("v%0d_alu_b", k), bus.alu_b, eb);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_valid", k), 32'(bus.out_valid), 1);
    chk($sformatf("v%0d_data", k), bus.out_data, v.e_data);
    chk($sformatf("v%0d_rd", k), 32'(bus.out_rd), 32'(v.rd));
    chk($sformatf("v%0d_wb", k), 32'(bus.out_wb_en), 32'(v.e_wb));
    chk($sformatf("v%0d_br", k), 32'(bus.out_br_taken), 32'(v.e_br));
  endtask

  // scoreboard monitor, sampled 2 time units after each falling edge
  bit          mon_en = 1'b0;
  res_t        q[$];
  bit          exp_err;
  bit          prev_stall = 1'b0;
  logic [31:0] p_data;
  logic [4:0]  p_rd;
  logic        p_wb;
  logic        p_br;
  int          n_out;

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      res_t r;
      chk("in_ready", 32'(bus.in_ready),
          32'(!bus.flush && (q.size() < 2 || bus.out_ready)));
      chk("err_illegal", 32'(bus.err_illegal), 32'(exp_err));
      if (q.size() == 0)
        chk("idle_out_valid", 32'(bus.out_valid), 0);
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", bus.out_data, p_data);
        chk("stall_rd", 32'(bus.out_rd), 32'(p_rd));
        chk("stall_wb", 32'(bus.out_wb_en), 32'(p_wb));
        chk("stall_br", 32'(bus.out_br_taken), 32'(p_br));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_valid), 0);
        end else begin
          r = q.pop_front();
          n_out++;
          chk("sb_data", bus.out_data, r.data);
          chk("sb_rd", 32'(bus.out_rd), 32'(r.rd));
          chk("sb_wb", 32'(bus.out_wb_en), 32'(r.wb));
          chk("sb_br", 32'(bus.out_br_taken), 32'(r.br));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_op[3])
          exp_err = 1'b1;
        else
          q.push_back(model(bus.in_op, bus.in_rs_val,
                            bus.in_rt_val, bus.in_imm, bus.in_rd));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      p_data = bus.out_data;
      p_rd   = bus.out_rd;
      p_wb   = bus.out_wb_en;
      p_br   = bus.out_br_taken;
    end
  end

  task automatic drain_all(input string nm);
    int budget;
    budget = 0;
    while (q.size() > 0 && budget < 40) begin
      @(negedge clk);
      idle();
      bus.out_ready = 1'b1;
      budget++;
    end
    @(negedge clk);
    #3 chk(nm, 32'(q.size()), 0);
  endtask

  initial begin
    logic [31:0] fexp;
    logic [3:0]  sop[8];
    logic [31:0] srs[8];
    logic [31:0] srt[8];
    int          si;
    int          c;

    vt[0] = '{4'd0, 32'd5, 32'd7, 16'h0000, 5'd3, 32'd12, 1'b1, 1'b0};
    vt[1] = '{4'd5, 32'd10, 32'd0, 16'hFFFF, 5'd4, 32'd9, 1'b1, 1'b0};
    vt[2] = '{4'd6, 32'd4, 32'd4, 16'h0000, 5'd0, 32'd0, 1'b0, 1'b1};
    vt[3] = '{4'd7, 32'd4, 32'd4, 16'h0000, 5'd0, 32'd0, 1'b0, 1'b0};
    vt[4] = '{4'd1, 32'd3, 32'd5, 16'h0000, 5'd7, 32'hFFFFFFFE, 1'b1, 1'b0};
    vt[5] = '{4'd2, 32'hF0F0, 32'hFF00, 16'h0, 5'd8, 32'hF000, 1'b1, 1'b0};
    vt[6] = '{4'd3, 32'hF0F0, 32'h0F0F, 16'h0, 5'd9, 32'hFFFF, 1'b1, 1'b0};
    vt[7] = '{4'd0, 32'd1, 32'd1, 16'h0000, 5'd0, 32'd2, 1'b0, 1'b0};
    vt[8] = '{4'd7, 32'd4, 32'd5, 16'h0000, 5'd6, 32'hFFFFFFFF, 1'b0, 1'b1};
    vt[9] = '{4'd5, 32'h7FFFFFFF, 32'd0, 16'h0001, 5'd31,
              32'h80000000, 1'b1, 1'b0};

    idle();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_rd", 32'(bus.out_rd), 0);
    chk("rst_wb", 32'(bus.out_wb_en), 0);
    chk("rst_br", 32'(bus.out_br_taken), 0);
    chk("rst_err", 32'(bus.err_illegal), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    for (int i = 0; i < 10; i++)
      run_vec(vt[i], i);

    // illegal op is consumed silently, then XOR still works
    @(negedge clk);
    idle();
    send(4'hC, 32'h1, 32'h2, 16'h0, 5'd1);
    bus.out_ready = 1'b1;
    #1 chk("ill_in_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      #1;
      chk("ill_no_out", 32'(bus.out_valid), 0);
      chk("ill_err", 32'(bus.err_illegal), 1);
    end
    run_vec('{4'd4, 32'hF0, 32'hFF, 16'h0, 5'd5, 32'h0F, 1'b1, 1'b0}, 10);
    @(negedge clk);
    #1 chk("ill_err_sticky", 32'(bus.err_illegal), 1);

    // flush with ID/EX full and MEM stalled
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(4'd0, 32'd1, 32'd2, 16'h0, 5'd1);
    @(negedge clk);
    send(4'd0, 32'd10, 32'd20, 16'h0, 5'd2);
    #1 chk("fl_accept_b", 32'(bus.in_ready), 1);
    @(negedge clk);
    send(4'd1, 32'd9, 32'd9, 16'h0, 5'd3);
    bus.flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 0);
    chk("fl_out_data", bus.out_data, 32'd3);
    @(negedge clk);
    idle();
    #1;
    chk("fl_hold_valid", 32'(bus.out_valid), 1);
    chk("fl_hold_data", bus.out_data, 32'd3);
    chk("fl_ready_after", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("fl_discarded", 32'(bus.out_valid), 0);
    end

    // dependent SUB with a stale rs value
`ifdef EX_FORWARD_EN
    fexp = 32'd4;
`else
    fexp = 32'hFFFFFFFF;
`endif
    @(negedge clk);
    send(4'd0, 32'd2, 32'd3, 16'h0, 5'd1);
    @(negedge clk);
    send(4'd1, 32'd0, 32'd1, 16'h0, 5'd2);
    bus.in_rs_idx = 5'd1;
    @(negedge clk);
    idle();
    #1 chk("fw_first", bus.out_data, 32'd5);
    @(negedge clk);
    #1 chk("fw_second", bus.out_data, fexp);

    // reset drops in-flight ops and clears the sticky error
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(4'hF, 32'd0, 32'd0, 16'h0, 5'd0);
    @(negedge clk);
    send(4'd0, 32'd1, 32'd1, 16'h0, 5'd4);
    @(negedge clk);
    send(4'd0, 32'd2, 32'd2, 16'h0, 5'd5);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_err", 32'(bus.err_illegal), 0);
    repeat (2) begin
      @(negedge clk);
      #1 chk("mid_rst_empty", 32'(bus.out_valid), 0);
    end

    // 8-op stream with out_ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      sop[i] = 4'($urandom_range(0, 7));
      srs[i] = $urandom;
      srt[i] = $urandom_range(0, 1) ? srs[i] : $urandom;
    end
    exp_err = 1'b0;
    n_out = 0;
    @(negedge clk);
    mon_en = 1'b1;
    si = 0;
    c = 0;
    while (si < 8 && c < 100) begin
      @(negedge clk);
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      send(sop[si], srs[si], srt[si], 16'($urandom), 5'(si + 1));
      #3;
      if (bus.in_valid && bus.in_ready) si++;
      c++;
    end
    chk("stream_all_sent", 32'(si), 8);
    drain_all("stream_drain");
    chk("stream_count", 32'(n_out), 8);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_op = ($urandom_range(0, 7) == 0)
                ? 4'(8 + $urandom_range(0, 7))
                : 4'($urandom_range(0, 7));
      bus.in_rs_val = $urandom_range(0, 1) ? $urandom
                                           : 32'($urandom_range(0, 3));
      bus.in_rt_val = $urandom_range(0, 1) ? $urandom
                                           : 32'($urandom_range(0, 3));
      bus.in_imm = 16'($urandom);
      bus.in_rd = 5'($urandom_range(0, 31));
      bus.in_rs_idx = '0;
      bus.in_rt_idx = '0;
      bus.flush = 1'b0;
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    drain_all("rand_drain");
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
